// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and the decode-queue entry type for the fetch unit
package fetch_pkg;
    localparam int unsigned XLEN_D = 32;
    localparam int unsigned DEPTH_D = 4;
    localparam int unsigned PC_STEP_D = 1;
    localparam logic [XLEN_D-1:0] RESET_PC_D = '0;
    typedef struct packed {
        logic [XLEN_D-1:0] pc;
        logic [XLEN_D-1:0] instr;
    } entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory request/response, redirect and decode handshakes of the fetch unit
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_D
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular FIFO with flush, count and full/empty flags
module fetch_fifo #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [W-1:0]         din,
    output logic [W-1:0]         dout,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(D):0]   count
);
    localparam int unsigned AW = $clog2(D);
    logic [W-1:0]  mem [D];
    logic [AW-1:0] rd, wr;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(D);
    assign empty   = count == '0;
    assign dout    = mem[rd];
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + AW'(1);
            if (do_pop) rd <= rd + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a bounded request window and redirect kill tracking
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_D,
    parameter int unsigned     DEPTH    = DEPTH_D,
    parameter int unsigned     PC_STEP  = PC_STEP_D,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_D)
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } q_entry_t;
    logic [XLEN-1:0] pc, tag_head;
    logic [CW-1:0]   q_count, t_count, kill;
    logic [CW+1:0]   inflight;
    logic            q_full, q_empty, t_full, t_empty;
    logic            req_fire, rsp_live, rsp_keep, pop_fire;
    q_entry_t        q_head, q_din;
    // Killed responses still occupy memory slots, so they count against the window.
    assign inflight           = (CW+2)'(q_count) + (CW+2)'(t_count) + (CW+2)'(kill);
    assign bus.imem_req_valid = rst_n && !bus.redirect_valid && !t_full && inflight < (CW+2)'(DEPTH);
    assign bus.imem_req_addr  = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_live           = bus.imem_rsp_valid && (kill != '0 || !t_empty);
    assign rsp_keep           = rsp_live && kill == '0 && !bus.redirect_valid;
    assign pop_fire           = bus.out_valid && bus.out_ready;
    assign bus.out_valid      = !q_empty;
    assign bus.out_pc         = q_head.pc;
    assign bus.out_instr      = q_head.instr;
    assign q_din              = '{pc: tag_head, instr: bus.imem_rsp_data};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= RESET_PC;
            kill <= '0;
        end else if (bus.redirect_valid) begin
            pc   <= bus.redirect_pc;
            kill <= kill + t_count - CW'(rsp_live);
        end else begin
            if (req_fire) pc <= pc + XLEN'(PC_STEP);
            if (rsp_live && kill != '0) kill <= kill - CW'(1);
        end
    end
    fetch_fifo #(.W(2*XLEN), .D(DEPTH)) u_iq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_keep),
        .pop   (pop_fire),
        .flush (bus.redirect_valid),
        .din   (q_din),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );
    fetch_fifo #(.W(XLEN), .D(DEPTH)) u_tag (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .pop   (rsp_keep),
        .flush (bus.redirect_valid),
        .din   (pc),
        .dout  (tag_head),
        .full  (t_full),
        .empty (t_empty),
        .count (t_count)
    );
    // The request window guarantees neither FIFO is ever pushed beyond capacity.
    assert property (@(posedge clk) disable iff (!rst_n) !(req_fire && t_full));
    assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && q_full && !pop_fire));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: redirect vector table, directed corner sequences and randomized scoreboard run
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam int unsigned DEPTH = 4;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] rpc; logic [31:0] a0; logic [31:0] a1; } vec_t;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;
    fetch_unit_if #(.XLEN(32)) bus();
    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    mreq_t       mq[$];
    logic [31:0] acc_log[$];
    entry_t      out_log[$];
    int tests = 0, fails = 0, cyc = 0, accepts = 0, outs = 0, first_acc = -1, first_ov = -1, lat = 1;
    logic req_rdy = 0, out_rdy = 0, redir = 0, stale = 0, prev_redir = 0;
    logic last_req_valid = 0, last_out_valid = 0;
    logic [31:0] redir_pc = 0, exp_req = 0, exp_out = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later, advance the model.
    task automatic tick();
        logic rsp;
        @(negedge clk);
        rsp = 1'b0;
        if (mq.size() != 0) rsp = mq[0].due <= cyc;
        bus.imem_rsp_valid = rsp || stale;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        if (rsp) bus.imem_rsp_data = instr_of(mq[0].addr);
        bus.imem_req_ready = req_rdy;
        bus.out_ready      = out_rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir_pc;
        stale = 0;
        #1;
        if (!rst_n) begin
            check("rst_req_valid", 32'(bus.imem_req_valid), 0);
            check("rst_out_valid", 32'(bus.out_valid), 0);
        end
        if (prev_redir && rst_n) check("post_redirect_out_valid", 32'(bus.out_valid), 0);
        if (redir) check("redirect_req_valid", 32'(bus.imem_req_valid), 0);
        if (bus.out_valid && first_ov < 0) first_ov = cyc;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", bus.imem_req_addr, exp_req);
            exp_req = exp_req + 32'd1;
            if (first_acc < 0) first_acc = cyc;
            mq.push_back('{bus.imem_req_addr, cyc + lat});
            acc_log.push_back(bus.imem_req_addr);
            accepts++;
        end
        if (bus.out_valid && bus.out_ready) begin
            check("out_pc", bus.out_pc, exp_out);
            check("out_instr", bus.out_instr, instr_of(exp_out));
            exp_out = exp_out + 32'd1;
            out_log.push_back('{pc: bus.out_pc, instr: bus.out_instr});
            outs++;
        end
        if (redir) begin
            exp_req = redir_pc;
            exp_out = redir_pc;
        end
        if (rsp) void'(mq.pop_front());
        if (rst_n) check("outstanding_le_depth", 32'(mq.size() <= DEPTH), 1);
        last_req_valid = bus.imem_req_valid;
        last_out_valid = bus.out_valid;
        prev_redir = redir && rst_n;
        redir = 0;
        @(posedge clk);
        cyc++;
    endtask

    // keep_stale: leave responses in flight across reset and inject one right after release.
    task automatic do_reset(input int n, input bit keep_stale);
        rst_n = 0;
        if (!keep_stale) mq.delete();
        repeat (n) tick();
        #1 rst_n = 1;
        mq.delete();
        stale = keep_stale;
        exp_req = 0;
        exp_out = 0;
        accepts = 0;
        outs = 0;
        first_acc = -1;
        first_ov = -1;
        prev_redir = 0;
        acc_log.delete();
        out_log.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[1] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0101};
        vecs[2] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0001};
        bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data  = 0;
        bus.redirect_valid = 0;
        bus.redirect_pc    = 0;
        bus.out_ready      = 0;

        // cold start: 2-cycle fill, then one instruction per cycle
        req_rdy = 1; out_rdy = 1; lat = 1;
        do_reset(2, 0);
        for (int i = 0; i < 12; i++) tick();
        check("fill_latency", 32'(first_ov - first_acc), 2);
        check("throughput", 32'(outs), 10);
        if (acc_log.size() > 0) check("first_addr", acc_log[0], 32'h0);

        // decode stalled: window fills to DEPTH, then drains in order
        req_rdy = 1; out_rdy = 0; lat = 1;
        do_reset(2, 0);
        for (int i = 0; i < 10; i++) tick();
        check("stall_requests", 32'(accepts), DEPTH);
        check("stall_req_valid_low", 32'(last_req_valid), 0);
        out_rdy = 1;
        for (int i = 0; i < 20 && outs < DEPTH; i++) tick();
        check("drain_count", 32'(outs), DEPTH);
        for (int i = 0; i < out_log.size(); i++) check("drain_pc", out_log[i].pc, 32'(i));

        // redirect table while streaming: a response always lands in the redirect cycle
        req_rdy = 1; out_rdy = 1; lat = 1;
        do_reset(2, 0);
        for (int v = 0; v < 4; v++) begin
            repeat (4) tick();
            redir = 1;
            redir_pc = vecs[v].rpc;
            tick();
            acc_log.delete();
            out_log.delete();
            for (int i = 0; i < 20 && out_log.size() < 2; i++) tick();
            check("vec_out_count", 32'(out_log.size()), 2);
            if (acc_log.size() >= 2) begin
                check("vec_req_addr0", acc_log[0], vecs[v].a0);
                check("vec_req_addr1", acc_log[1], vecs[v].a1);
            end
            if (out_log.size() >= 2) begin
                check("vec_out_pc0", out_log[0].pc, vecs[v].a0);
                check("vec_out_pc1", out_log[1].pc, vecs[v].a1);
                check("vec_out_instr0", out_log[0].instr, instr_of(vecs[v].a0));
            end
        end

        // redirect with three requests in flight and no response yet
        req_rdy = 1; out_rdy = 1; lat = 5;
        do_reset(2, 0);
        for (int i = 0; i < 10 && accepts < 3; i++) tick();
        req_rdy = 0;
        check("kill_setup_accepts", 32'(accepts), 3);
        check("kill_setup_no_output", 32'(first_ov), 32'hFFFF_FFFF);
        redir = 1;
        redir_pc = 32'h100;
        req_rdy = 1;
        tick();
        out_log.delete();
        for (int i = 0; i < 40 && out_log.size() < 2; i++) tick();
        check("kill_out_count", 32'(out_log.size()), 2);
        if (out_log.size() >= 2) begin
            check("kill_out_pc0", out_log[0].pc, 32'h100);
            check("kill_out_pc1", out_log[1].pc, 32'h101);
        end

        // async reset with queue half full and two responses outstanding
        req_rdy = 1; out_rdy = 0; lat = 3;
        do_reset(2, 0);
        repeat (5) tick();
        check("prefill_out_valid", 32'(last_out_valid), 1);
        check("prefill_accepts", 32'(accepts), DEPTH);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 0);
        check("async_rst_req_valid", 32'(bus.imem_req_valid), 0);
        out_rdy = 1; lat = 1;
        do_reset(3, 1);
        for (int i = 0; i < 20 && out_log.size() < 4; i++) tick();
        check("restart_out_count", 32'(out_log.size()), 4);
        if (out_log.size() >= 1) begin
            check("restart_pc", out_log[0].pc, 32'h0);
            check("restart_instr", out_log[0].instr, instr_of(32'h0));
        end

        // randomized traffic, latency and redirects
        do_reset(2, 0);
        for (int i = 0; i < 10000; i++) begin
            req_rdy = $urandom_range(0, 3) != 0;
            out_rdy = $urandom_range(0, 3) != 0;
            lat = int'($urandom_range(1, 5));
            if ($urandom_range(0, 59) == 0) begin
                redir = 1;
                redir_pc = ($urandom_range(0, 1) != 0) ? $urandom : 32'hFFFF_FFFD + 32'($urandom_range(0, 3));
            end
            tick();
        end
        check("random_progress", 32'(outs > 2000), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, 32, width of PC, addresses and instruction words.
REQ-002 Parameter DEPTH, 4, instruction-queue entries and maximum outstanding memory requests; power of two, >=2.
REQ-003 Parameter PC_STEP, 1, PC increment per fetched word (word addressing).
REQ-004 Parameter RESET_PC, 0, PC value after reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 imem_req_valid  out  1  fetch request presented.
REQ-008 imem_req_ready  in  1  memory accepts request this cycle.
REQ-009 imem_req_addr  out  XLEN  fetch address.
REQ-010 imem_rsp_valid  in  1  response word valid; responses return in request order, latency >=1 cycle.
REQ-011 imem_rsp_data  in  XLEN  fetched instruction word.
REQ-012 redirect_valid  in  1  branch/jump redirect, single-cycle pulse.
REQ-013 redirect_pc  in  XLEN  new fetch PC.
REQ-014 out_valid  out  1  instruction available to decode.
REQ-015 out_ready  in  1  decode accepts instruction.
REQ-016 out_instr  out  XLEN  instruction word at queue head.
REQ-017 out_pc  out  XLEN  PC of out_instr.

Function
REQ-018 Request handshake: request accepted when imem_req_valid && imem_req_ready; imem_req_addr = fetch PC; PC += PC_STEP on acceptance, wrapping modulo 2^XLEN.
REQ-019 imem_req_valid = (queue occupancy + outstanding) < DEPTH && !redirect_valid; occupancy+outstanding never exceeds DEPTH.
REQ-020 Each accepted request pushes its address into an in-order tag FIFO; each live response pairs with the oldest tag and is written to the queue in the same cycle.
REQ-021 Output handshake: entry popped when out_valid && out_ready; out_valid = queue non-empty; head stable while out_valid && !out_ready.
REQ-022 Latency: with zero-latency-ready memory returning in 1 cycle, first instruction appears at out_valid 2 cycles after request acceptance; sustained throughput 1 instruction/cycle.
REQ-023 Simultaneous push and pop on a full queue is legal; occupancy unchanged.
REQ-024 Redirect: in the cycle redirect_valid is high, queue and tag FIFO flush; PC <= redirect_pc; out_valid low next cycle; no request issued in the redirect cycle.
REQ-025 In-flight requests at redirect are recorded in a kill counter; the next kill-count responses are discarded; kill counter decrements per discarded response.
REQ-026 Response arriving in the redirect cycle is discarded and counted against the kill counter.
REQ-027 New requests after redirect are permitted while kill counter is non-zero; budget of REQ-019 counts killed responses as outstanding.
REQ-028 Response with no outstanding request is a protocol error; it is ignored and state is unchanged.
REQ-029 Redirect to PC 2^XLEN-1 then two fetches yields addresses 2^XLEN-1, 0.

Reset
REQ-030 Async assert on rst_n low: PC=RESET_PC, queue empty, tag FIFO empty, outstanding=0, kill=0, out_valid=0, imem_req_valid=0 while in reset.
REQ-031 Deassertion synchronised; first request may issue on the first rising edge after release.
REQ-032 Reset mid-operation abandons in-flight responses; responses arriving after reset with no outstanding request follow REQ-028.

Structure
REQ-033 Shared package fetch_pkg holds default XLEN, DEPTH, PC_STEP, RESET_PC and the queue-entry type {pc, instr}.
REQ-034 One sub-module fetch_fifo (parametrised width/depth, push/pop/flush, full/empty, count) instantiated twice: instruction queue and tag FIFO.
REQ-035 No combinational path from imem_rsp_valid to imem_req_valid.

Verification
REQ-036 Reset, memory always ready, 1-cycle response, out_ready=1: addresses 0,1,2,3... and out_pc/out_instr match in order, one per cycle after 2-cycle fill.
REQ-037 out_ready=0 for 10 cycles: exactly DEPTH requests issued, imem_req_valid low afterwards; releasing out_ready drains DEPTH entries in order with none lost.
REQ-038 Redirect to 0x100 with 3 requests outstanding: 3 subsequent responses discarded, next out_pc=0x100, 0x101.
REQ-039 Response and redirect in the same cycle: response discarded, first output after redirect has out_pc=redirect_pc.
REQ-040 Random imem_req_ready/latency (1-5 cycles) and out_ready with random redirects, 10k cycles: scoreboard sees in-order PCs per redirect segment, outstanding never >DEPTH.
REQ-041 rst_n asserted with queue half-full and 2 outstanding: outputs clear immediately; after release fetch restarts at RESET_PC; stale responses ignored.
